// File: rtl/msb_pkg.sv
// Shared typedefs and constants for the read-tag issue path.
// Widths match the default TAGS=32 / WAYS=16 configuration.
package msb_pkg;
    localparam int DEF_TAGS = 32;
    localparam int DEF_WAYS = 16;
    localparam int LINE_B   = 128;

    typedef logic [$clog2(DEF_TAGS)-1:0] tag_t;
    typedef logic [$clog2(DEF_WAYS)-1:0] sid_t;
endpackage

// File: rtl/req_tag_pool.sv
// Free-tag bit vector with lowest-free priority pick and an allocated count.
// The pick is taken from the registered vector, so a tag freed this cycle is not handed out again until the next cycle.
module req_tag_pool #(
    parameter int TAGS  = 32,
    parameter int TAG_W = $clog2(TAGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_i,
    input  logic             free_i,
    input  logic [TAG_W-1:0] free_tag_i,
    input  logic [TAG_W-1:0] qry_tag_i,
    output logic [TAG_W-1:0] alloc_tag_o,
    output logic             full_o,
    output logic [TAG_W:0]   count_o,
    output logic             qry_alloc_o
);
    logic [TAGS-1:0] free_q, free_d;
    logic [TAG_W:0]  count_q, count_d;

    always_comb begin
        alloc_tag_o = '0;
        for (int t = TAGS - 1; t >= 0; t--) begin
            if (free_q[t]) alloc_tag_o = TAG_W'(t);
        end
        full_o      = ~|free_q;
        qry_alloc_o = ~free_q[qry_tag_i];
        count_o     = count_q;
    end

    // Allocation and free never target the same tag: alloc picks a free bit,
    // the caller only frees an allocated one.
    always_comb begin
        free_d  = free_q;
        count_d = count_q;
        if (alloc_i) free_d[alloc_tag_o] = 1'b0;
        if (free_i)  free_d[free_tag_i]  = 1'b1;
        case ({alloc_i, free_i})
            2'b10:   count_d = count_q + (TAG_W+1)'(1);
            2'b01:   count_d = count_q - (TAG_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            free_q  <= '1;
            count_q <= '0;
        end else begin
            free_q  <= free_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/req_tag_issue.sv
// Turns merged per-stream requests into tagged line reads: allocates a tag,
// computes base + offset*LINE_B, and holds the command in a ready/valid output stage.
module req_tag_issue
    import msb_pkg::*;
#(
    parameter int WAYS   = 16,
    parameter int TAGS   = 32,
    parameter int ADDR_W = 64,
    parameter int LINE_B = msb_pkg::LINE_B,
    parameter int OFF_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_v,
    output logic                     i_r,
    input  logic [$clog2(WAYS)-1:0]  i_sel,
    input  logic [WAYS*ADDR_W-1:0]   cfg_base,
    input  logic [WAYS-1:0]          cfg_start,
    output logic                     o_v,
    input  logic                     o_r,
    output logic [ADDR_W-1:0]        o_addr,
    output logic [$clog2(TAGS)-1:0]  o_tag,
    input  logic                     rsp_v,
    input  logic [$clog2(TAGS)-1:0]  rsp_tag,
    output logic [$clog2(WAYS)-1:0]  rsp_sid,
    output logic [$clog2(TAGS):0]    o_outstanding,
    output logic                     o_err
);
    localparam int TAG_W   = $clog2(TAGS);
    localparam int SID_W   = $clog2(WAYS);
    localparam int LINE_SH = $clog2(LINE_B);

    logic             full, acc, rsp_alloc, rsp_hit;
    logic [TAG_W-1:0] pick_tag;

    logic [SID_W-1:0] tbl_q [TAGS];

    logic [WAYS-1:0][OFF_W-1:0] off_q, off_d;
    logic [OFF_W-1:0]           off_eff;
    logic [ADDR_W-1:0]          base_sel, acc_addr;

    logic              ov_q, ov_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              err_q, err_d;

    req_tag_pool #(.TAGS(TAGS), .TAG_W(TAG_W)) u_pool (
        .clk         (clk),
        .reset       (reset),
        .alloc_i     (acc),
        .free_i      (rsp_hit),
        .free_tag_i  (rsp_tag),
        .qry_tag_i   (rsp_tag),
        .alloc_tag_o (pick_tag),
        .full_o      (full),
        .count_o     (o_outstanding),
        .qry_alloc_o (rsp_alloc)
    );

    assign i_r     = !full && (!ov_q || o_r);
    assign acc     = i_v && i_r;
    assign rsp_hit = rsp_v && rsp_alloc;
    assign rsp_sid = tbl_q[rsp_tag];

    // A start pulse in the accept cycle wins over the stored offset.
    always_comb begin
        off_eff  = cfg_start[i_sel] ? '0 : off_q[i_sel];
        base_sel = cfg_base[i_sel*ADDR_W +: ADDR_W];
        acc_addr = base_sel + (ADDR_W'(off_eff) << LINE_SH);
        off_d    = off_q;
        for (int s = 0; s < WAYS; s++) begin
            if (cfg_start[s]) off_d[s] = '0;
        end
        if (acc) off_d[i_sel] = off_eff + OFF_W'(1);
    end

    always_comb begin
        ov_d   = ov_q;
        addr_d = addr_q;
        tag_d  = tag_q;
        err_d  = err_q | (rsp_v && !rsp_alloc);
        if (acc) begin
            ov_d   = 1'b1;
            addr_d = acc_addr;
            tag_d  = pick_tag;
        end else if (o_r) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ov_q  <= 1'b0;
            err_q <= 1'b0;
            off_q <= '0;
        end else begin
            ov_q  <= ov_d;
            err_q <= err_d;
            off_q <= off_d;
        end
    end

    // Payload and tag table need no reset: qualified by o_v and tag allocation.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        tag_q  <= tag_d;
        if (acc) tbl_q[pick_tag] <= i_sel;
    end

    assign o_v    = ov_q;
    assign o_addr = addr_q;
    assign o_tag  = tag_q;
    assign o_err  = err_q;
endmodule

// File: tb/tb_req_tag_issue.sv
// Directed bench for req_tag_issue: address/tag table plus hand-written
// sequences for full, backpressure, concurrent free, error and start cases.
module tb_req_tag_issue;
    import msb_pkg::*;

    localparam int WAYS = 16, TAGS = 32, ADDR_W = 64;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   i_v, i_r, o_v, o_r, rsp_v, o_err;
    logic [3:0]             i_sel, rsp_sid;
    logic [WAYS*ADDR_W-1:0] cfg_base;
    logic [WAYS-1:0]        cfg_start;
    logic [ADDR_W-1:0]      o_addr;
    logic [4:0]             o_tag, rsp_tag;
    logic [5:0]             o_outstanding;

    int n_tests = 0, n_fail = 0;

    req_tag_issue #(.WAYS(WAYS), .TAGS(TAGS), .ADDR_W(ADDR_W), .LINE_B(128), .OFF_W(16)) dut (
        .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r), .i_sel(i_sel),
        .cfg_base(cfg_base), .cfg_start(cfg_start), .o_v(o_v), .o_r(o_r),
        .o_addr(o_addr), .o_tag(o_tag), .rsp_v(rsp_v), .rsp_tag(rsp_tag),
        .rsp_sid(rsp_sid), .o_outstanding(o_outstanding), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          sid;
        bit          start;
        logic [63:0] addr;
        int          tag;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int sid, input bit start, input logic [63:0] ea, input int et, input string nm);
        i_sel = 4'(sid);
        i_v   = 1'b1;
        cfg_start[sid] = start;
        #1 chk({nm, " i_r"}, 64'(i_r), 64'd1);
        step();
        i_v = 1'b0;
        cfg_start = '0;
        chk({nm, " o_v"}, 64'(o_v), 64'd1);
        chk({nm, " addr"}, o_addr, ea);
        chk({nm, " tag"}, 64'(o_tag), 64'(et));
    endtask

    task automatic rsp(input int tag, input int exp_sid);
        rsp_v   = 1'b1;
        rsp_tag = 5'(tag);
        #1;
        if (exp_sid >= 0) chk("rsp_sid", 64'(rsp_sid), 64'(exp_sid));
        step();
        rsp_v = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n_acc;
        logic [63:0] hold_addr;
        logic [4:0]  hold_tag;

        tbl[0] = '{3,  0, 64'h1000, 0};
        tbl[1] = '{3,  0, 64'h1080, 1};
        tbl[2] = '{3,  0, 64'h1100, 2};
        tbl[3] = '{5,  0, 64'h2000_0000_0000_0000, 3};
        tbl[4] = '{5,  0, 64'h2000_0000_0000_0080, 4};
        tbl[5] = '{3,  1, 64'h1000, 5};
        tbl[6] = '{3,  0, 64'h1080, 6};
        tbl[7] = '{15, 0, 64'hFFFF_FFFF_FFFF_FF80, 7};
        tbl[8] = '{15, 0, 64'h0, 8};

        i_v = 0; i_sel = 0; cfg_start = '0; o_r = 1; rsp_v = 0; rsp_tag = 0;
        cfg_base = '0;
        cfg_base[3*ADDR_W +: ADDR_W]  = 64'h1000;
        cfg_base[5*ADDR_W +: ADDR_W]  = 64'h2000_0000_0000_0000;
        cfg_base[2*ADDR_W +: ADDR_W]  = 64'h4000;
        cfg_base[4*ADDR_W +: ADDR_W]  = 64'h8000;
        cfg_base[15*ADDR_W +: ADDR_W] = 64'hFFFF_FFFF_FFFF_FF80;
        do_reset();

        chk("reset o_v", 64'(o_v), 0);
        chk("reset outstanding", 64'(o_outstanding), 0);
        chk("reset o_err", 64'(o_err), 0);
        chk("reset i_r", 64'(i_r), 1);

        // Address / tag table, output always ready
        for (int k = 0; k < 9; k++)
            issue(tbl[k].sid, tbl[k].start, tbl[k].addr, tbl[k].tag, $sformatf("vec%0d", k));
        chk("table outstanding", 64'(o_outstanding), 9);
        for (int k = 0; k < 9; k++) rsp(k, tbl[k].sid);
        chk("table drained", 64'(o_outstanding), 0);
        chk("table no err", 64'(o_err), 0);

        // Fill all tags, then free tag 5 and reuse it
        i_sel = 4'd1;
        i_v   = 1'b1;
        n_acc = 0;
        for (int c = 0; c < 40; c++) begin
            if (!i_r) break;
            n_acc++;
            step();
        end
        chk("full accepts", 64'(n_acc), 32);
        chk("full i_r", 64'(i_r), 0);
        chk("full outstanding", 64'(o_outstanding), 32);
        chk("full last tag", 64'(o_tag), 31);
        rsp_v = 1'b1;
        rsp_tag = 5'd5;
        #1 chk("free cycle i_r", 64'(i_r), 0);
        chk("free rsp_sid", 64'(rsp_sid), 1);
        step();
        rsp_v = 1'b0;
        chk("after free i_r", 64'(i_r), 1);
        step();
        i_v = 1'b0;
        chk("reuse tag", 64'(o_tag), 5);
        chk("reuse o_v", 64'(o_v), 1);
        chk("reuse outstanding", 64'(o_outstanding), 32);
        for (int k = 0; k < 32; k++) rsp(k, -1);
        chk("full drained", 64'(o_outstanding), 0);

        // Backpressure holds the command
        o_r = 1'b0;
        issue(2, 0, 64'h4000, 0, "bp");
        hold_addr = o_addr;
        hold_tag  = o_tag;
        i_v = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("bp i_r", 64'(i_r), 0);
            chk("bp o_v", 64'(o_v), 1);
            chk("bp addr", o_addr, hold_addr);
            chk("bp tag", 64'(o_tag), 64'(hold_tag));
            step();
        end
        i_v = 1'b0;
        o_r = 1'b1;
        step();
        chk("bp released o_v", 64'(o_v), 0);
        chk("bp outstanding", 64'(o_outstanding), 1);
        rsp(0, 2);

        // Same-cycle accept and free with 4 outstanding
        for (int k = 0; k < 4; k++) issue(4, 0, 64'h8000 + 64'(k) * 64'h80, k, "cf");
        chk("cf outstanding pre", 64'(o_outstanding), 4);
        i_sel = 4'd4;
        i_v = 1'b1;
        rsp_v = 1'b1;
        rsp_tag = 5'd0;
        #1 chk("cf i_r", 64'(i_r), 1);
        step();
        i_v = 1'b0;
        rsp_v = 1'b0;
        chk("cf outstanding", 64'(o_outstanding), 4);
        chk("cf new tag", 64'(o_tag), 4);
        for (int k = 1; k < 5; k++) rsp(k, 4);

        // Completion of a free tag
        rsp(7, -1);
        chk("err set", 64'(o_err), 1);
        chk("err outstanding", 64'(o_outstanding), 0);
        step();
        step();
        chk("err sticky", 64'(o_err), 1);

        // Start pulse concurrent with request at offset 9
        for (int k = 0; k < 8; k++)
            issue(2, 0, 64'h4080 + 64'(k) * 64'h80, k, "adv");
        chk("adv last addr", o_addr, 64'h4400);
        for (int k = 0; k < 8; k++) rsp(k, 2);
        issue(2, 1, 64'h4000, 0, "start");
        issue(2, 0, 64'h4080, 1, "post start");
        rsp(0, 2);
        rsp(1, 2);

        // Reset with a command in flight
        o_r = 1'b0;
        issue(2, 0, 64'h4100, 0, "inflight");
        do_reset();
        o_r = 1'b1;
        chk("midreset o_v", 64'(o_v), 0);
        chk("midreset outstanding", 64'(o_outstanding), 0);
        chk("midreset o_err", 64'(o_err), 0);
        rsp(0, -1);
        chk("late rsp err", 64'(o_err), 1);
        issue(2, 0, 64'h4000, 0, "post reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/req_tag_issue.md
REQ_TAG_ISSUE -- requirements
Module: req_tag_issue

Interface
REQ-001 Parameter WAYS, 16, number of streams (power of 2).
REQ-002 Parameter TAGS, 32, outstanding read tags (power of 2).
REQ-003 Parameter ADDR_W, 64, byte address width.
REQ-004 Parameter LINE_B, 128, cache-line bytes (power of 2).
REQ-005 Parameter OFF_W, 16, per-stream line-offset counter width.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 i_v / i_r  in / out  1 / 1  merged request handshake from the request merger.
REQ-009 i_sel  in  $clog2(WAYS)  stream id of the request.
REQ-010 cfg_base  in  WAYS*ADDR_W  per-stream line-aligned base address; stream s at bits [s*ADDR_W +: ADDR_W].
REQ-011 cfg_start  in  WAYS  per-stream pulse; clears that stream's line offset.
REQ-012 o_v / o_r  out / in  1 / 1  read command handshake to memory interface.
REQ-013 o_addr  out  ADDR_W  read byte address.
REQ-014 o_tag  out  $clog2(TAGS)  tag of the command.
REQ-015 rsp_v  in  1  read completion; always accepted.
REQ-016 rsp_tag  in  $clog2(TAGS)  tag being completed.
REQ-017 rsp_sid  out  $clog2(WAYS)  stream id owning rsp_tag, combinational from tag table, valid when rsp_v.
REQ-018 o_outstanding  out  $clog2(TAGS)+1  count of allocated tags.
REQ-019 o_err  out  1  sticky: completion for unallocated tag.

Function
REQ-020 Block SHALL hold a free-tag bit vector, a tag-to-stream table (TAGS x $clog2(WAYS)) and per-stream line offsets (WAYS x OFF_W).
REQ-021 i_r SHALL be 1 iff at least one tag is free AND output register is empty or o_r=1 this cycle.
REQ-022 On i_v&&i_r the block SHALL allocate the lowest-numbered free tag, record i_sel in the table, and load the output register next cycle (latency 1).
REQ-023 o_addr SHALL equal cfg_base[i_sel] + offset[i_sel]*LINE_B, computed at acceptance, truncated to ADDR_W.
REQ-024 offset[i_sel] SHALL increment by 1 on acceptance, wrapping modulo 2^OFF_W.
REQ-025 o_v/o_addr/o_tag SHALL stay stable while o_v&&!o_r.
REQ-026 On rsp_v with allocated rsp_tag the tag SHALL be freed at the next edge; freed tag SHALL NOT be reallocated in the same cycle it completes.
REQ-027 On rsp_v with unallocated rsp_tag: no state change except o_err set to 1.
REQ-028 Simultaneous allocate and free SHALL leave o_outstanding unchanged.
REQ-029 cfg_start[s] together with acceptance of stream s: offset SHALL be cleared first, request uses offset 0, stored offset becomes 1.
REQ-030 TAGS allocated: i_r=0 until a completion frees a tag; no request lost or duplicated.

Reset
REQ-031 On reset: all tags free, o_v=0, o_outstanding=0, o_err=0, all offsets 0; tag table contents don't-care.
REQ-032 Reset mid-operation SHALL discard in-flight command and all tags; completions arriving after reset SHALL set o_err.

Structure
REQ-033 Shared package msb_pkg SHALL hold tag_t, sid_t typedefs and LINE_B constant.
REQ-034 Free-tag vector with lowest-free priority pick SHALL be sub-module req_tag_pool (alloc/free ports, full flag, count).
REQ-035 Output register SHALL be a base_areg-compatible ready/valid stage.

Verification
REQ-036 Reset, cfg_base[3]=0x1000, three requests sid=3, o_r=1 -> addrs 0x1000,0x1080,0x1100, tags 0,1,2, o_outstanding=3.
REQ-037 Issue 32 requests without completions -> i_r=0 after 32nd; rsp tag 5 -> next accepted request gets tag 5 one cycle later.
REQ-038 o_r=0 for 4 cycles with o_v=1 -> o_addr/o_tag stable, i_r=0; o_r=1 -> exactly one transfer.
REQ-039 Same-cycle accept and rsp of tag 0 with outstanding=4 -> outstanding stays 4, new tag != 0.
REQ-040 rsp_tag=7 when tag 7 free -> o_err=1 and stays 1 until reset; outstanding unchanged.
REQ-041 cfg_start[2] pulse concurrent with sid=2 request at offset 9 -> o_addr=cfg_base[2]; next sid=2 request uses offset 1.
